// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard inputs, memory handshake and the resulting
// freeze/flush controls exchanged between the datapath and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int REG_ADDR_LEN = 5
);
  logic                    fwd_en;
  logic [REG_ADDR_LEN-1:0] id_src1;
  logic [REG_ADDR_LEN-1:0] id_src2;
  logic                    id_two_src;
  logic [REG_ADDR_LEN-1:0] ex_dest;
  logic [REG_ADDR_LEN-1:0] mem_dest;
  logic                    ex_wb_en;
  logic                    mem_wb_en;
  logic                    ex_mem_r_en;
  logic                    br_taken;
  logic                    mem_req;
  logic                    sram_ready;
  logic                    pc_freeze;
  logic                    if2id_freeze;
  logic                    if2id_flush;
  logic                    id2ex_flush;
  logic                    pipe_freeze;
  logic                    mem_start;
  logic                    mem_timeout;
  logic [15:0]             stall_cnt;

  modport master (
    output fwd_en, id_src1, id_src2, id_two_src, ex_dest, mem_dest,
           ex_wb_en, mem_wb_en, ex_mem_r_en, br_taken, mem_req, sram_ready,
    input  pc_freeze, if2id_freeze, if2id_flush, id2ex_flush, pipe_freeze,
           mem_start, mem_timeout, stall_cnt
  );

  modport slave (
    input  fwd_en, id_src1, id_src2, id_two_src, ex_dest, mem_dest,
           ex_wb_en, mem_wb_en, ex_mem_r_en, br_taken, mem_req, sram_ready,
    output pc_freeze, if2id_freeze, if2id_flush, id2ex_flush, pipe_freeze,
           mem_start, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: memory-access sequencer with timeout,
// data-hazard detection (with/without forwarding) and prioritised freeze/flush.
//
// state | meaning
// IDLE  | no memory access; mem_req launches one
// BUSY  | waiting for sram_ready or timeout, whole pipe frozen
// DONE  | one free cycle after an access, mem_req ignored
module pipe_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int MEM_TIMEOUT  = 15
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       to_set;
  logic       mem_stall;
  logic       data_hz;
  logic       hz_full;
  logic       hz_load_use;

  function automatic logic match(input logic [REG_ADDR_LEN-1:0] a,
                                 input logic [REG_ADDR_LEN-1:0] d,
                                 input logic                    en);
    return en && (d != '0) && (a == d);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.mem_timeout <= 1'b0;
      bus.stall_cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (to_set)
        bus.mem_timeout <= 1'b1;
      if (bus.pc_freeze && (bus.stall_cnt != 16'hFFFF))
        bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    to_set        = 1'b0;
    mem_stall     = 1'b0;
    bus.mem_start = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_req) begin
          bus.mem_start = 1'b1;
          mem_stall     = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (bus.sram_ready) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (cnt_nxt == TIMEOUT_VAL) begin
            state_nxt = DONE;
            to_set    = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Without forwarding any pending writer hazards; with it only a load in EX does.
  always_comb begin
    hz_full = match(bus.id_src1, bus.ex_dest, bus.ex_wb_en)
           || match(bus.id_src1, bus.mem_dest, bus.mem_wb_en)
           || (bus.id_two_src && (match(bus.id_src2, bus.ex_dest, bus.ex_wb_en)
                               || match(bus.id_src2, bus.mem_dest, bus.mem_wb_en)));
    hz_load_use = match(bus.id_src1, bus.ex_dest, bus.ex_wb_en && bus.ex_mem_r_en)
               || (bus.id_two_src
                   && match(bus.id_src2, bus.ex_dest, bus.ex_wb_en && bus.ex_mem_r_en));
    data_hz = bus.fwd_en ? hz_load_use : hz_full;
  end

  always_comb begin
    bus.pc_freeze    = 1'b0;
    bus.if2id_freeze = 1'b0;
    bus.if2id_flush  = 1'b0;
    bus.id2ex_flush  = 1'b0;
    bus.pipe_freeze  = 1'b0;
    if (mem_stall) begin
      bus.pc_freeze    = 1'b1;
      bus.if2id_freeze = 1'b1;
      bus.pipe_freeze  = 1'b1;
    end else if (bus.br_taken) begin
      bus.if2id_flush = 1'b1;
      bus.id2ex_flush = 1'b1;
    end else if (data_hz) begin
      bus.pc_freeze    = 1'b1;
      bus.if2id_freeze = 1'b1;
      bus.id2ex_flush  = 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the memory sequencer and hazard rules.
module tb_pipe_ctrl;
  localparam int AW = 5;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.REG_ADDR_LEN(AW)) bus ();

  pipe_ctrl #(.REG_ADDR_LEN(AW), .MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // {pc_freeze, if2id_freeze, if2id_flush, id2ex_flush, pipe_freeze}
  function automatic logic [4:0] ctrl();
    return {bus.pc_freeze, bus.if2id_freeze, bus.if2id_flush, bus.id2ex_flush, bus.pipe_freeze};
  endfunction

  task automatic clear_inputs();
    bus.fwd_en = 0; bus.id_src1 = '0; bus.id_src2 = '0; bus.id_two_src = 0;
    bus.ex_dest = '0; bus.mem_dest = '0; bus.ex_wb_en = 0; bus.mem_wb_en = 0;
    bus.ex_mem_r_en = 0; bus.br_taken = 0; bus.mem_req = 0; bus.sram_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.mem_req = 1;
    rst = 0;
    #2;
    n_vec++;
    if (bus.mem_timeout !== 1'b0 || bus.stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_regs: timeout=%b stall_cnt=%0d, want 0/0", bus.mem_timeout, bus.stall_cnt);
    end
    n_vec++;
    if ({ctrl(), bus.mem_start} !== 6'b110011) begin
      n_err++;
      $display("FAIL reset_idle_eval: ctrl/start=%b, want 110011", {ctrl(), bus.mem_start});
    end
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({ctrl(), bus.mem_start, bus.mem_timeout} !== 7'b0 || bus.stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_release: outs=%b cnt=%0d, want 0", {ctrl(), bus.mem_start, bus.mem_timeout}, bus.stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.fwd_en = 1; bus.ex_mem_r_en = 1; bus.ex_wb_en = 1; bus.ex_dest = 5; bus.id_src1 = 5;
    @(negedge clk);
    n_vec++;
    if (ctrl() !== 5'b11010) begin
      n_err++; $display("FAIL load_use: ctrl=%b, want 11010", ctrl());
    end
    next_cycle();
    bus.ex_dest = 0; bus.id_src1 = 0;
    @(negedge clk);
    n_vec++;
    if (ctrl() !== 5'b00000) begin
      n_err++; $display("FAIL load_use_r0: ctrl=%b, want 00000", ctrl());
    end
    next_cycle();
    bus.ex_dest = 5; bus.id_src1 = 5; bus.ex_mem_r_en = 0;
    @(negedge clk);
    n_vec++;
    if (ctrl() !== 5'b00000) begin
      n_err++; $display("FAIL fwd_alu: ctrl=%b, want 00000", ctrl());
    end
    n_vec++;
    if (bus.stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL load_use_cnt: stall_cnt=%0d, want 1", bus.stall_cnt);
    end
  endtask

  task automatic test_no_fwd();
    do_reset();
    bus.fwd_en = 0; bus.mem_wb_en = 1; bus.mem_dest = 7; bus.id_two_src = 1;
    bus.id_src2 = 7; bus.id_src1 = 3;
    @(negedge clk);
    n_vec++;
    if (ctrl() !== 5'b11010) begin
      n_err++; $display("FAIL nofwd_src2: ctrl=%b, want 11010", ctrl());
    end
    next_cycle();
    bus.id_two_src = 0;
    @(negedge clk);
    n_vec++;
    if (ctrl() !== 5'b00000) begin
      n_err++; $display("FAIL nofwd_one_src: ctrl=%b, want 00000", ctrl());
    end
  endtask

  task automatic test_mem_access();
    int frz;
    do_reset();
    bus.mem_req = 1;
    @(negedge clk);
    n_vec++;
    if (bus.mem_start !== 1'b1 || bus.pipe_freeze !== 1'b1) begin
      n_err++; $display("FAIL mem_launch: start=%b freeze=%b, want 1/1", bus.mem_start, bus.pipe_freeze);
    end
    frz = 1;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      bus.mem_req = 0;
      bus.sram_ready = (k == 3);
      @(negedge clk);
      if (bus.pipe_freeze === 1'b1) frz++;
      n_vec++;
      if (bus.mem_start !== 1'b0) begin
        n_err++; $display("FAIL mem_start_once: cycle %0d start=%b, want 0", k, bus.mem_start);
      end
    end
    next_cycle();
    bus.sram_ready = 0;
    bus.mem_req = 1;
    @(negedge clk);
    n_vec++;
    if (frz !== 4 || ctrl() !== 5'b0 || bus.mem_start !== 1'b0) begin
      n_err++; $display("FAIL mem_free_cycle: frz=%0d ctrl=%b start=%b, want 4/0/0", frz, ctrl(), bus.mem_start);
    end
    n_vec++;
    if (bus.stall_cnt !== 16'd4) begin
      n_err++; $display("FAIL mem_stall_cnt: stall_cnt=%0d, want 4", bus.stall_cnt);
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    if (bus.mem_start !== 1'b1) begin
      n_err++; $display("FAIL mem_relaunch: start=%b, want 1", bus.mem_start);
    end
  endtask

  // ready_at: BUSY cycle index (1-based) carrying sram_ready, 0 = never
  task automatic run_access(input int ready_at, output int frz);
    frz = 0;
    bus.mem_req = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.pipe_freeze !== 1'b1) break;
      frz++;
      next_cycle();
      bus.mem_req = 1;
      bus.sram_ready = (ready_at != 0) && (k + 1 == ready_at);
    end
    bus.sram_ready = 0;
    bus.mem_req = 0;
  endtask

  task automatic test_timeout();
    int frz;
    do_reset();
    run_access(0, frz);
    n_vec++;
    if (frz !== TO + 1 || bus.mem_timeout !== 1'b1) begin
      n_err++; $display("FAIL timeout: frz=%0d timeout=%b, want %0d/1", frz, bus.mem_timeout, TO + 1);
    end
    repeat (3) next_cycle();
    run_access(2, frz);
    @(negedge clk);
    n_vec++;
    if (bus.mem_timeout !== 1'b1 || frz !== 3) begin
      n_err++; $display("FAIL timeout_sticky: timeout=%b frz=%0d, want 1/3", bus.mem_timeout, frz);
    end
    do_reset();
    run_access(TO, frz);
    @(negedge clk);
    n_vec++;
    if (bus.mem_timeout !== 1'b0 || frz !== TO + 1) begin
      n_err++; $display("FAIL ready_at_limit: timeout=%b frz=%0d, want 0/%0d", bus.mem_timeout, frz, TO + 1);
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.ex_wb_en = 1; bus.ex_dest = 5; bus.id_src1 = 5; bus.br_taken = 1;
    @(negedge clk);
    n_vec++;
    if (ctrl() !== 5'b00110) begin
      n_err++; $display("FAIL br_over_hz: ctrl=%b, want 00110", ctrl());
    end
    bus.mem_req = 1;
    #1;
    n_vec++;
    if (ctrl() !== 5'b11001) begin
      n_err++; $display("FAIL mem_over_br: ctrl=%b, want 11001", ctrl());
    end
    next_cycle();
    bus.mem_req = 0;
    @(negedge clk);
    n_vec++;
    if (ctrl() !== 5'b11001) begin
      n_err++; $display("FAIL busy_over_br: ctrl=%b, want 11001", ctrl());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.mem_req = 1;
    next_cycle();
    bus.mem_req = 0;
    next_cycle();
    #2;
    rst = 0;
    #1;
    n_vec++;
    if ({ctrl(), bus.mem_start, bus.mem_timeout} !== 7'b0 || bus.stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL async_reset: outs=%b cnt=%0d, want 0/0", {ctrl(), bus.mem_start, bus.mem_timeout}, bus.stall_cnt);
    end
    next_cycle();
    rst = 1;
    repeat (2) next_cycle();
    @(negedge clk);
    n_vec++;
    if (ctrl() !== 5'b0 || bus.mem_start !== 1'b0 || bus.stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL abandon_access: ctrl=%b start=%b cnt=%0d, want 0", ctrl(), bus.mem_start, bus.stall_cnt);
    end
  endtask

  task automatic test_random(input int n);
    bit in_access = 0;
    bit recovering = 0;
    bit timed_out = 0;
    int waited = 0;
    int stalls = 0;
    do_reset();
    for (int c = 0; c < n; c++) begin
      bit stall_now, start_now, hz;
      logic [4:0] exp_ctrl;
      int srcs[$];
      int dests[$];
      next_cycle();
      bus.fwd_en      = $urandom_range(0, 1);
      bus.id_src1     = AW'($urandom_range(0, 3));
      bus.id_src2     = AW'($urandom_range(0, 3));
      bus.id_two_src  = $urandom_range(0, 1);
      bus.ex_dest     = AW'($urandom_range(0, 3));
      bus.mem_dest    = AW'($urandom_range(0, 3));
      bus.ex_wb_en    = $urandom_range(0, 1);
      bus.mem_wb_en   = $urandom_range(0, 1);
      bus.ex_mem_r_en = $urandom_range(0, 1);
      bus.br_taken    = ($urandom_range(0, 3) == 0);
      bus.mem_req     = ($urandom_range(0, 3) == 0);
      bus.sram_ready  = ($urandom_range(0, 6) == 0);

      start_now = !in_access && !recovering && bus.mem_req;
      stall_now = in_access || start_now;
      srcs.push_back(int'(bus.id_src1));
      if (bus.id_two_src) srcs.push_back(int'(bus.id_src2));
      if (bus.fwd_en) begin
        if (bus.ex_wb_en && bus.ex_mem_r_en) dests.push_back(int'(bus.ex_dest));
      end else begin
        if (bus.ex_wb_en)  dests.push_back(int'(bus.ex_dest));
        if (bus.mem_wb_en) dests.push_back(int'(bus.mem_dest));
      end
      hz = 0;
      foreach (srcs[i])
        foreach (dests[j])
          if (srcs[i] != 0 && srcs[i] == dests[j]) hz = 1;
      if (stall_now)         exp_ctrl = 5'b11001;
      else if (bus.br_taken) exp_ctrl = 5'b00110;
      else if (hz)           exp_ctrl = 5'b11010;
      else                   exp_ctrl = 5'b00000;

      @(negedge clk);
      n_vec++;
      if ({ctrl(), bus.mem_start} !== {exp_ctrl, start_now}) begin
        n_err++;
        $display("FAIL rand_ctrl: cycle %0d ctrl/start=%b, want %b", c, {ctrl(), bus.mem_start}, {exp_ctrl, start_now});
      end
      n_vec++;
      if (bus.stall_cnt !== 16'(stalls) || bus.mem_timeout !== timed_out) begin
        n_err++;
        $display("FAIL rand_regs: cycle %0d cnt=%0d timeout=%b, want %0d/%b", c, bus.stall_cnt, bus.mem_timeout, stalls, timed_out);
      end

      if (exp_ctrl[4] && stalls < 65535) stalls++;
      if (recovering) begin
        recovering = 0;
      end else if (in_access) begin
        if (bus.sram_ready) begin
          in_access = 0; recovering = 1;
        end else begin
          waited++;
          if (waited == TO) begin
            in_access = 0; recovering = 1; timed_out = 1;
          end
        end
      end else if (bus.mem_req) begin
        in_access = 1; waited = 0;
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_fwd();
    test_mem_access();
    test_timeout();
    test_priority();
    test_async_reset();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
